// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Holds the register file geometry and the arbiter FSM state
// encoding. It also defines the entry format kept in the
// long-latency-unit result buffer, plus a helper that tells
// whether a destination is a real architectural write.
package rf_arb_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam int NREG   = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FORCE
  } arb_state_e;

  typedef struct packed {
    logic [REG_AW-1:0] waddr;
    logic [REG_DW-1:0] wdata;
  } lu_entry_t;

  // x0 is hardwired to zero, so a write aimed at it carries no information.
  function automatic logic isRealDest(input logic [REG_AW-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// DEPTH-entry synchronous FIFO that buffers long-latency-unit results
// until they win the register file write port.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (flushes contents)
//   push_i        store push_data_i at the tail (ignored when full)
//   push_data_i   {waddr, wdata} entry to store
//   pop_i         drop the head entry (ignored when empty)
//   head_o        oldest stored entry, valid while !empty_o
//   full_o        count_o == DEPTH
//   empty_o       count_o == 0
//   count_o       number of stored entries
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  lu_entry_t        push_data_i,
  input  logic             pop_i,
  output lu_entry_t        head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  lu_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next-state for the pointers and occupancy; a simultaneous push and pop
  // leaves the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = nextPtr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = nextPtr(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Reset empties the FIFO by clearing occupancy and pointers; stale storage
  // contents are unreachable afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset because occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the register file's single write port between pipeline writeback
// (WB) and a long-latency unit (LU). LU results wait in a small FIFO. A
// 32-entry pending scoreboard tracks outstanding LU destinations so decode
// can be stalled on a hazard. A starvation FSM asks the pipeline to stall
// when WB keeps winning the port.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wb_we/waddr/wdata        writeback write request (highest priority)
//   lu_valid/waddr/wdata     LU result offer; lu_ready = buffer has room
//   sb_set, sb_addr          decode issued an LU op targeting sb_addr
//   chk_re*/chk_raddr*       decode read ports checked against pending set
//   hazard                   decode must stall this cycle
//   pipe_stall               starvation stall request (Moore, FORCE state)
//   rf_we/waddr/wdata        regfile write port
module rf_wport_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_waddr,
  input  logic [REG_DW-1:0] wb_wdata,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_AW-1:0] lu_waddr,
  input  logic [REG_DW-1:0] lu_wdata,
  input  logic              sb_set,
  input  logic [REG_AW-1:0] sb_addr,
  input  logic              chk_re1,
  input  logic [REG_AW-1:0] chk_raddr1,
  input  logic              chk_re2,
  input  logic [REG_AW-1:0] chk_raddr2,
  output logic              hazard,
  output logic              pipe_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [REG_DW-1:0] rf_wdata
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int DCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [DCNT_W-1:0] DENY_LIMIT = DCNT_W'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [DCNT_W-1:0] deny_q, deny_d;
  logic [NREG-1:0]   pend_q, pend_d;

  lu_entry_t         push_entry;
  lu_entry_t         fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  logic              wb_grant;
  logic              lu_grant;
  logic              lu_push;
  logic              buf_empties;
  logic              pend1;
  logic              pend2;

  assign push_entry = '{waddr: lu_waddr, wdata: lu_wdata};

  // A WB write to x0 is a no-op, so it does not claim the port.
  assign wb_grant = wb_we && isRealDest(wb_waddr);
  assign lu_grant = !wb_grant && !fifo_empty;

  // Readiness looks at the occupancy before any same-cycle pop, so a full
  // buffer refuses even while its head is draining.
  assign lu_ready = !rst && !fifo_full;

  // Results for x0 complete the handshake but are never stored.
  assign lu_push = lu_valid && lu_ready && isRealDest(lu_waddr);

  // True when this cycle's pop drains the last entry and nothing refills it.
  assign buf_empties = lu_grant && !lu_push && (fifo_count == CNT_W'(1));

  rf_arb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (lu_push),
    .push_data_i (push_entry),
    .pop_i       (lu_grant),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Write-port mux: WB first, then the buffered LU head. All write outputs
  // are forced low while reset is asserted.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!rst) begin
      if (wb_grant) begin
        rf_we    = 1'b1;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end else if (lu_grant) begin
        rf_we    = 1'b1;
        rf_waddr = fifo_head.waddr;
        rf_wdata = fifo_head.wdata;
      end
    end
  end

  // Starvation FSM. The deny counter counts cycles where WB took the port
  // while LU data was waiting. Any LU grant clears it. Reaching the limit
  // enters FORCE, where the counter simply holds (saturates) until LU wins.
  always_comb begin
    state_d = state_q;
    deny_d  = deny_q;
    case (state_q)
      IDLE: begin
        deny_d = '0;
        if (lu_push) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lu_grant) begin
          deny_d = '0;
          if (buf_empties) begin
            state_d = IDLE;
          end
        end else if (wb_grant) begin
          deny_d = deny_q + DCNT_W'(1);
          if (deny_q + DCNT_W'(1) == DENY_LIMIT) begin
            state_d = FORCE;
          end
        end
      end
      FORCE: begin
        if (lu_grant) begin
          deny_d  = '0;
          state_d = buf_empties ? IDLE : WAIT;
        end
      end
      default: begin
        state_d = IDLE;
        deny_d  = '0;
      end
    endcase
  end

  // FSM state and deny counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      deny_q  <= '0;
    end else begin
      state_q <= state_d;
      deny_q  <= deny_d;
    end
  end

  assign pipe_stall = !rst && (state_q == FORCE);

  // Pending scoreboard update. The clear for the retiring LU destination is
  // applied first so that a same-cycle re-issue to that register stays
  // pending.
  always_comb begin
    pend_d = pend_q;
    if (lu_grant) begin
      pend_d[fifo_head.waddr] = 1'b0;
    end
    if (sb_set && isRealDest(sb_addr)) begin
      pend_d[sb_addr] = 1'b1;
    end
  end

  // Pending scoreboard register; reset drops all outstanding destinations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // A register being written by the LU this cycle is not a hazard because
  // the regfile write bypass delivers its value to decode in the same cycle.
  assign pend1 = pend_q[chk_raddr1] && isRealDest(chk_raddr1) &&
                 !(lu_grant && (fifo_head.waddr == chk_raddr1));
  assign pend2 = pend_q[chk_raddr2] && isRealDest(chk_raddr2) &&
                 !(lu_grant && (fifo_head.waddr == chk_raddr2));

  assign hazard = !rst && ((chk_re1 && pend1) || (chk_re2 && pend2));

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed testbench for rf_wport_arbiter. Every expected regfile write is
// queued when its stimulus is issued; an independent monitor pops and
// compares whenever the DUT asserts rf_we. Status outputs (hazard,
// pipe_stall, lu_ready) are compared directly against hand-derived values.
module tb_rf_wport_arbiter;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        chk_re1;
  logic [4:0]  chk_raddr1;
  logic        chk_re2;
  logic [4:0]  chk_raddr2;
  logic        hazard;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  exp_t expQ[$];
  int   passCount  = 0;
  int   checkCount = 0;

  rf_wport_arbiter #(
    .DEPTH        (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_we      (wb_we),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_waddr   (lu_waddr),
    .lu_wdata   (lu_wdata),
    .sb_set     (sb_set),
    .sb_addr    (sb_addr),
    .chk_re1    (chk_re1),
    .chk_raddr1 (chk_raddr1),
    .chk_re2    (chk_re2),
    .chk_raddr2 (chk_raddr2),
    .hazard     (hazard),
    .pipe_stall (pipe_stall),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectWrite(input logic [4:0] addr, input logic [31:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    expQ.push_back(e);
  endtask

  // Advances to just after the next rising edge and drives the WB/LU inputs.
  task automatic applyStimulus(input logic wbWe, input logic [4:0] wbAddr,
                               input logic [31:0] wbData, input logic luValid,
                               input logic [4:0] luAddr, input logic [31:0] luData);
    @(posedge clk);
    #1;
    wb_we    = wbWe;
    wb_waddr = wbAddr;
    wb_wdata = wbData;
    lu_valid = luValid;
    lu_waddr = luAddr;
    lu_wdata = luData;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Scoreboard monitor: every observed regfile write must match the oldest
  // queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rf_we) begin
        checkCount++;
        if (expQ.size() == 0) begin
          $display("[TB] FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                   rf_waddr, rf_wdata);
        end else begin
          e = expQ.pop_front();
          if (rf_waddr === e.addr && rf_wdata === e.data) begin
            passCount++;
          end else begin
            $display("[TB] FAIL rf_write: got addr %0d data 0x%0h, expected addr %0d data 0x%0h",
                     rf_waddr, rf_wdata, e.addr, e.data);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    wb_we      = 1'b1;
    wb_waddr   = 5'd3;
    wb_wdata   = 32'h33;
    lu_valid   = 1'b0;
    lu_waddr   = 5'd0;
    lu_wdata   = 32'h0;
    sb_set     = 1'b0;
    sb_addr    = 5'd0;
    chk_re1    = 1'b0;
    chk_raddr1 = 5'd0;
    chk_re2    = 1'b0;
    chk_raddr2 = 5'd0;

    // Reset: outputs held low even with a WB request present.
    #2;
    checkOutput("reset_rf_we", rf_we, 0);
    checkOutput("reset_lu_ready", lu_ready, 0);
    checkOutput("reset_pipe_stall", pipe_stall, 0);
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    wb_we = 1'b0;
    #1;
    checkOutput("post_reset_lu_ready", lu_ready, 1);
    checkOutput("post_reset_rf_we", rf_we, 0);

    // LU result is written the cycle after it is accepted.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    expectWrite(5'd5, 32'hDEAD_BEEF);
    #1;
    checkOutput("lu_push_ready", lu_ready, 1);
    checkOutput("lu_push_no_write_yet", rf_we, 0);
    idleCycle();
    #1;
    checkOutput("lu_write_we", rf_we, 1);
    checkOutput("lu_write_addr", rf_waddr, 5);
    checkOutput("lu_write_no_stall", pipe_stall, 0);
    idleCycle();
    #1;
    checkOutput("lu_drained", rf_we, 0);

    // Scoreboard hazard on r7 until its LU grant cycle.
    idleCycle();
    sb_set     = 1'b1;
    sb_addr    = 5'd7;
    chk_re1    = 1'b1;
    chk_raddr1 = 5'd7;
    #1;
    checkOutput("hazard_before_set", hazard, 0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h0000_7777);
    expectWrite(5'd7, 32'h0000_7777);
    sb_set     = 1'b0;
    chk_re1    = 1'b0;
    chk_re2    = 1'b1;
    chk_raddr2 = 5'd7;
    #1;
    checkOutput("hazard_port2_pending", hazard, 1);
    chk_re2 = 1'b0;
    #1;
    checkOutput("hazard_read_disabled", hazard, 0);
    idleCycle();
    chk_re1    = 1'b1;
    chk_raddr1 = 5'd7;
    #1;
    checkOutput("hazard_bypass_on_grant", hazard, 0);
    checkOutput("grant_r7_addr", rf_waddr, 7);
    idleCycle();
    #1;
    checkOutput("hazard_after_clear", hazard, 0);
    chk_re1 = 1'b0;

    // Starvation: WB r3 keeps winning against one buffered LU entry.
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'h0000_C0C0);
    expectWrite(5'd3, 32'h33);
    #1;
    checkOutput("starve_c0_no_stall", pipe_stall, 0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
      expectWrite(5'd3, 32'h33);
      #1;
      checkOutput($sformatf("starve_deny%0d_no_stall", i), pipe_stall, 0);
    end
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    expectWrite(5'd3, 32'h33);
    #1;
    checkOutput("starve_force_stall", pipe_stall, 1);
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    expectWrite(5'd3, 32'h33);
    #1;
    checkOutput("starve_force_held", pipe_stall, 1);
    checkOutput("starve_lu_ready", lu_ready, 1);
    idleCycle();
    expectWrite(5'd12, 32'h0000_C0C0);
    #1;
    checkOutput("force_grant_stall", pipe_stall, 1);
    checkOutput("force_grant_addr", rf_waddr, 12);
    idleCycle();
    #1;
    checkOutput("force_exit_idle", pipe_stall, 0);
    checkOutput("force_exit_no_write", rf_we, 0);

    // Fill both entries, hold a third offer; x0 WB writes free the port.
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd20, 32'h0000_A0A0);
    expectWrite(5'd1, 32'h11);
    #1;
    checkOutput("fill0_ready", lu_ready, 1);
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd21, 32'h0000_B1B1);
    expectWrite(5'd1, 32'h11);
    #1;
    checkOutput("fill1_ready", lu_ready, 1);
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd22, 32'h0000_C2C2);
    expectWrite(5'd1, 32'h11);
    #1;
    checkOutput("full_not_ready", lu_ready, 0);
    applyStimulus(1'b1, 5'd0, 32'h11, 1'b1, 5'd22, 32'h0000_C2C2);
    expectWrite(5'd20, 32'h0000_A0A0);
    #1;
    checkOutput("full_pop_not_ready", lu_ready, 0);
    checkOutput("wb_x0_frees_port", rf_waddr, 20);
    applyStimulus(1'b1, 5'd0, 32'h11, 1'b1, 5'd22, 32'h0000_C2C2);
    expectWrite(5'd21, 32'h0000_B1B1);
    #1;
    checkOutput("after_pop_ready", lu_ready, 1);
    idleCycle();
    expectWrite(5'd22, 32'h0000_C2C2);
    #1;
    checkOutput("held_entry_written", rf_waddr, 22);
    idleCycle();
    #1;
    checkOutput("fill_drained", rf_we, 0);
    checkOutput("fill_no_stall", pipe_stall, 0);

    // Set and clear of r9 in the same cycle: set wins. x0 never hazards.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0000_9999);
    expectWrite(5'd9, 32'h0000_9999);
    idleCycle();
    sb_set     = 1'b1;
    sb_addr    = 5'd9;
    chk_re1    = 1'b1;
    chk_raddr1 = 5'd9;
    #1;
    checkOutput("r9_not_yet_pending", hazard, 0);
    idleCycle();
    sb_addr = 5'd0;
    #1;
    checkOutput("r9_set_wins", hazard, 1);
    chk_re1    = 1'b0;
    chk_re2    = 1'b1;
    chk_raddr2 = 5'd0;
    #1;
    checkOutput("x0_no_hazard", hazard, 0);
    idleCycle();
    sb_set = 1'b0;
    #1;
    checkOutput("x0_never_pending", hazard, 0);
    chk_re2    = 1'b0;
    chk_re1    = 1'b1;
    chk_raddr1 = 5'd9;

    // Reset in the middle of FORCE with two buffered entries.
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd10, 32'h0000_AAAA);
    expectWrite(5'd4, 32'h44);
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd11, 32'h0000_BBBB);
    expectWrite(5'd4, 32'h44);
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
    expectWrite(5'd4, 32'h44);
    #1;
    checkOutput("two_entries_not_ready", lu_ready, 0);
    repeat (2) begin
      applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
      expectWrite(5'd4, 32'h44);
    end
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("pre_reset_force", pipe_stall, 1);
    checkOutput("pre_reset_hazard_r9", hazard, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_reset_rf_we", rf_we, 0);
    checkOutput("mid_reset_pipe_stall", pipe_stall, 0);
    checkOutput("mid_reset_lu_ready", lu_ready, 0);
    checkOutput("mid_reset_hazard", hazard, 0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wb_we = 1'b0;
    #1;
    checkOutput("release_lu_ready", lu_ready, 1);
    checkOutput("release_pipe_stall", pipe_stall, 0);
    checkOutput("release_pending_flushed", hazard, 0);
    idleCycle();
    #1;
    checkOutput("release_buffer_flushed", rf_we, 0);
    chk_re1 = 1'b0;

    repeat (3) idleCycle();
    checkOutput("expected_writes_outstanding", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
